// File: rtl/writeback_pkg.sv
// writeback_pkg
// Shared definitions for the writeback serializer: channel count and slot
// width defaults, the channel-ID enum, the per-channel meaningful-width table,
// the serializer FSM state enum and the slot masking helper.
// Ports: none (package).
package writeback_pkg;

    localparam int unsigned WB_NUM_CH  = 10;
    localparam int unsigned WB_SLOT_W  = 40;
    localparam int unsigned WB_CH_ID_W = 4;

    typedef enum logic [3:0] {
        CH_CQHEAD         = 4'd0,
        CH_SQPSN          = 4'd1,
        CH_LSTRQREQ       = 4'd2,
        CH_INSRRPKTCNT    = 4'd3,
        CH_INAMPKTCNT     = 4'd4,
        CH_INNCKPKTSTS    = 4'd5,
        CH_OUTAMPKTCNT    = 4'd6,
        CH_OUTNAKPKTCNT   = 4'd7,
        CH_OUTIOPKTCNT    = 4'd8,
        CH_OUTRDRSPPKTCNT = 4'd9
    } wb_chan_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } wb_state_e;

    // Meaningful width of each channel's slot; unknown IDs carry nothing.
    function automatic logic [6:0] chan_width(input logic [WB_CH_ID_W-1:0] ch);
        logic [6:0] w;
        case (ch)
            CH_CQHEAD:         w = 7'd40;
            CH_SQPSN:          w = 7'd40;
            CH_LSTRQREQ:       w = 7'd40;
            CH_INSRRPKTCNT:    w = 7'd32;
            CH_INAMPKTCNT:     w = 7'd32;
            CH_INNCKPKTSTS:    w = 7'd32;
            CH_OUTAMPKTCNT:    w = 7'd32;
            CH_OUTNAKPKTCNT:   w = 7'd16;
            CH_OUTIOPKTCNT:    w = 7'd32;
            CH_OUTRDRSPPKTCNT: w = 7'd32;
            default:           w = 7'd0;
        endcase
        return w;
    endfunction

    // Keep only the low 'width' bits of a slot and zero-extend to 64 bits.
    function automatic logic [63:0] mask_slot(input logic [WB_SLOT_W-1:0] slot,
                                              input logic [6:0]           width);
        logic [63:0] r;
        r = 64'd0;
        for (int b = 0; b < int'(WB_SLOT_W); b++) begin
            r[b] = (b < int'(width)) ? slot[b] : 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_prio_enc.sv
// wb_prio_enc
// Purely combinational fixed-priority encoder: reports the index of the
// lowest set bit of a vector and whether any bit is set.
// Ports:
//   vec      input  N      request vector
//   idx      output IDX_W  index of lowest set bit (0 when none set)
//   any_set  output 1      at least one bit of vec is set
module wb_prio_enc #(
    parameter int unsigned N     = 10,
    parameter int unsigned IDX_W = 4
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any_set
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        idx     = {IDX_W{1'b0}};
        any_set = |vec;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            idx = vec[i] ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/writeback_serializer.sv
// writeback_serializer
// Pops a set of valid channel slots from the CDC stage in one strobe and
// issues them as 64-bit host write requests, one per channel, lowest channel
// first, to base + channel*8. All request outputs are registered; the next
// request is computed from the post-edge pending set so capture-to-request
// latency is one cycle and bursts run back-to-back.
// Ports:
//   clk_i            input   clock, rising edge
//   rst_i            input   synchronous active-high reset
//   wb_valid_i       input   any CDC channel valid
//   wb_ready_o       output  pop strobe to CDC stage (high in IDLE)
//   wb_chan_valid_i  input   per-channel valid
//   wb_chan_data_i   input   per-channel slots, channel k at [k*SLOT_W +: SLOT_W]
//   wb_base_addr_i   input   host writeback area base address
//   wr_valid_o       output  write request valid
//   wr_ready_i       input   write request accepted
//   wr_addr_o        output  write address
//   wr_data_o        output  write data, masked and zero-extended
//   wr_chan_o        output  channel ID of current request
//   wr_cnt_o         output  completed write handshakes (wraps)
module writeback_serializer #(
    parameter int unsigned WB_NUM_CH = writeback_pkg::WB_NUM_CH,
    parameter int unsigned WB_SLOT_W = writeback_pkg::WB_SLOT_W,
    parameter int unsigned WR_ADDR_W = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wb_valid_i,
    output logic                           wb_ready_o,
    input  logic [WB_NUM_CH-1:0]           wb_chan_valid_i,
    input  logic [WB_NUM_CH*WB_SLOT_W-1:0] wb_chan_data_i,
    input  logic [WR_ADDR_W-1:0]           wb_base_addr_i,
    output logic                           wr_valid_o,
    input  logic                           wr_ready_i,
    output logic [WR_ADDR_W-1:0]           wr_addr_o,
    output logic [63:0]                    wr_data_o,
    output logic [3:0]                     wr_chan_o,
    output logic [31:0]                    wr_cnt_o
);

    import writeback_pkg::*;

    localparam int unsigned ID_W = WB_CH_ID_W;

    wb_state_e                state_r;
    wb_state_e                state_next_s;
    logic [WB_NUM_CH-1:0]     pend_r;
    logic [WB_NUM_CH-1:0]     pend_next_s;
    logic [WB_NUM_CH-1:0]     clear_s;
    logic [WR_ADDR_W-1:0]     base_r;
    logic [WR_ADDR_W-1:0]     base_next_s;
    logic [WB_SLOT_W-1:0]     slot_r    [WB_NUM_CH];
    logic [WB_SLOT_W-1:0]     slot_in_s [WB_NUM_CH];
    logic [WB_SLOT_W-1:0]     slot_sel_s;
    logic                     capture_s;
    logic                     hs_s;
    logic [ID_W-1:0]          idx_next_s;
    logic                     any_next_s;
    logic [WR_ADDR_W-1:0]     addr_next_s;
    logic [63:0]              data_next_s;

    logic                     wr_valid_r;
    logic                     wb_ready_r;
    logic [WR_ADDR_W-1:0]     wr_addr_r;
    logic [63:0]              wr_data_r;
    logic [3:0]               wr_chan_r;
    logic [31:0]              wr_cnt_r;

    assign hs_s    = wr_valid_r & wr_ready_i;
    assign clear_s = {{(WB_NUM_CH-1){1'b0}}, 1'b1} << wr_chan_r;

    // Unpack the flat CDC data bus into one slot per channel.
    always_comb begin
        for (int k = 0; k < int'(WB_NUM_CH); k++) begin
            slot_in_s[k] = wb_chan_data_i[k*WB_SLOT_W +: WB_SLOT_W];
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state, capture decision and pending-set update.
    always_comb begin
        state_next_s = state_r;
        pend_next_s  = pend_r;
        base_next_s  = base_r;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (wb_valid_i) begin
                    capture_s    = 1'b1;
                    pend_next_s  = wb_chan_valid_i;
                    // Writeback area is 8-byte aligned regardless of what the host programmed.
                    base_next_s  = wb_base_addr_i & {{(WR_ADDR_W-3){1'b1}}, 3'b000};
                    state_next_s = (wb_chan_valid_i != {WB_NUM_CH{1'b0}}) ? ISSUE : IDLE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (hs_s) begin
                    pend_next_s  = pend_r & ~clear_s;
                    state_next_s = (|(pend_r & ~clear_s)) ? ISSUE : IDLE;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            default: begin
                state_next_s = IDLE;
                pend_next_s  = {WB_NUM_CH{1'b0}};
            end
        endcase
    end

    wb_prio_enc #(
        .N     (WB_NUM_CH),
        .IDX_W (ID_W)
    ) u_prio_enc (
        .vec     (pend_next_s),
        .idx     (idx_next_s),
        .any_set (any_next_s)
    );

    // Next request contents; on a capture edge the slot comes straight from
    // the input bus since slot_r has not been loaded yet.
    always_comb begin
        slot_sel_s = {WB_SLOT_W{1'b0}};
        if (any_next_s && (idx_next_s < ID_W'(WB_NUM_CH))) begin
            slot_sel_s = capture_s ? slot_in_s[idx_next_s] : slot_r[idx_next_s];
        end else begin
            slot_sel_s = {WB_SLOT_W{1'b0}};
        end
        addr_next_s = base_next_s + (WR_ADDR_W'(idx_next_s) << 3);
        data_next_s = mask_slot(slot_sel_s, chan_width(idx_next_s));
    end

    // Datapath state and registered request outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_r     <= {WB_NUM_CH{1'b0}};
            base_r     <= {WR_ADDR_W{1'b0}};
            for (int k = 0; k < int'(WB_NUM_CH); k++) begin
                slot_r[k] <= {WB_SLOT_W{1'b0}};
            end
            wr_cnt_r   <= 32'd0;
            wr_valid_r <= 1'b0;
            wb_ready_r <= 1'b1;
            wr_addr_r  <= {WR_ADDR_W{1'b0}};
            wr_data_r  <= 64'd0;
            wr_chan_r  <= 4'd0;
        end else begin
            pend_r <= pend_next_s;
            base_r <= base_next_s;
            for (int k = 0; k < int'(WB_NUM_CH); k++) begin
                if (capture_s && wb_chan_valid_i[k]) begin
                    slot_r[k] <= slot_in_s[k];
                end
            end
            if (hs_s) begin
                wr_cnt_r <= wr_cnt_r + 32'd1;
            end
            wr_valid_r <= (state_next_s == ISSUE) && any_next_s;
            wb_ready_r <= (state_next_s == IDLE);
            if ((state_next_s == ISSUE) && any_next_s) begin
                wr_addr_r <= addr_next_s;
                wr_data_r <= data_next_s;
                wr_chan_r <= 4'(idx_next_s);
            end else begin
                wr_addr_r <= {WR_ADDR_W{1'b0}};
                wr_data_r <= 64'd0;
                wr_chan_r <= 4'd0;
            end
        end
    end

    assign wb_ready_o = wb_ready_r;
    assign wr_valid_o = wr_valid_r;
    assign wr_addr_o  = wr_addr_r;
    assign wr_data_o  = wr_data_r;
    assign wr_chan_o  = wr_chan_r;
    assign wr_cnt_o   = wr_cnt_r;

endmodule

// File: doc/writeback_serializer.md
WRITEBACK_SERIALIZER -- requirements
Module: writeback_serializer

Interface
REQ-001 Parameters SHALL be:
- WB_NUM_CH, default 10, number of writeback channels.
- WB_SLOT_W, default 40, per-channel data slot width.
- WR_ADDR_W, default 64, write address width.

REQ-002 Ports SHALL be:
- clk_i  input  1  single clock; all logic on its rising edge.
- rst_i  input  1  reset, synchronous and active-high.
- wb_valid_i  input  1  OR of all channel valids from the CDC stage.
- wb_ready_o  output  1  pop strobe, shared by all CDC channels.
- wb_chan_valid_i  input  WB_NUM_CH  per-channel valid; bit index = channel ID.
- wb_chan_data_i  input  WB_NUM_CH*WB_SLOT_W  channel k data in slot [k*40 +: 40].
- wb_base_addr_i  input  WR_ADDR_W  host writeback area base address.
- wr_valid_o  output  1  write request valid.
- wr_ready_i  input  1  write request accepted.
- wr_addr_o  output  WR_ADDR_W  write address.
- wr_data_o  output  64  write data, zero-extended.
- wr_chan_o  output  4  channel ID of the current request.
- wr_cnt_o  output  32  count of completed write handshakes.

Function
REQ-003 Channel map SHALL be: 0 CQHEADi(40), 1 SQPSNi(40), 2 LSTRQREQi(40), 3 INSRRPKTCNT(32), 4 INAMPKTCNT(32), 5 INNCKPKTSTS(32), 6 OUTAMPKTCNT(32), 7 OUTNAKPKTCNT(16), 8 OUTIOPKTCNT(32), 9 OUTRDRSPPKTCNT(32); the value in parentheses is the meaningful width.
REQ-004 FSM SHALL have two states:
- IDLE: wb_ready_o=1, wr_valid_o=0.
- ISSUE: wb_ready_o=0.
REQ-005 Capture: in IDLE with wb_valid_i=1, the block SHALL, on that edge:
- latch pend_q<=wb_chan_valid_i;
- latch each valid channel's slot;
- latch base_q<=wb_base_addr_i with bits [2:0] forced to 0;
- go to ISSUE if wb_chan_valid_i!=0, else stay in IDLE.
REQ-006 In ISSUE, wr_valid_o SHALL be 1 and SHALL select the lowest-index set bit of pend_q (fixed priority).
REQ-007 wr_addr_o SHALL equal base_q + (channel ID * 8), modulo 2^WR_ADDR_W.
REQ-008 wr_data_o SHALL be the latched slot masked to the channel's meaningful width, zero-extended to 64 bits; slot bits above that width SHALL be ignored.
REQ-009 While wr_valid_o=1 and wr_ready_i=0, wr_addr_o, wr_data_o and wr_chan_o SHALL hold stable.
REQ-010 On a handshake (wr_valid_o & wr_ready_i), the selected pend_q bit SHALL clear and wr_cnt_o SHALL increment by 1, wrapping 0xFFFFFFFF->0.
REQ-011 Consecutive requests SHALL issue back-to-back, one per cycle, while wr_ready_i=1.
REQ-012 When the handshake clears the last pend_q bit, the FSM SHALL return to IDLE, with wb_ready_o=1 on the next cycle.
REQ-013 Capture-to-first-request latency SHALL be exactly 1 cycle; with wr_ready_i=1 throughout, an N-channel burst SHALL occupy N cycles in ISSUE.
REQ-014 Changes to wb_base_addr_i or wb_chan_data_i during ISSUE SHALL have no effect on requests in flight.
REQ-015 wb_valid_i arriving during ISSUE SHALL NOT be popped; the CDC stage holds it until IDLE.

Reset
REQ-016 While rst_i=1 at a clock edge, the block SHALL clear pend_q, base_q, all data slots and wr_cnt_o to 0, and enter IDLE.
REQ-017 Output values during and after reset SHALL be: wr_valid_o=0, wb_ready_o=1 (in IDLE), wr_addr_o=0, wr_data_o=0, wr_chan_o=0, wr_cnt_o=0.
REQ-018 A reset asserted mid-burst SHALL discard all pending channels, with wr_valid_o=0 in the following cycle.

Structure
REQ-019 Package writeback_pkg SHALL hold:
- WB_NUM_CH;
- the channel-ID enum;
- the per-channel width table (REQ-003);
- the FSM state enum {IDLE, ISSUE}.
REQ-020 One sub-module, wb_prio_enc, SHALL take a WB_NUM_CH-bit vector and produce the lowest-set-bit index plus an any-set flag; it SHALL be purely combinational.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single channel: base=0x1000, chan 0 valid, data=0xAB_CDEF_0123, wr_ready_i=1 -> one request, addr=0x1000, data=0x000000ABCDEF0123, chan=0, wr_cnt_o=1, IDLE next cycle.
- All 10 valid, wr_ready_i=1 -> 10 consecutive cycles, chans 0..9, addrs base+0x00..base+0x48; chan 7 slot 0xFF_FFFF_1234 -> data=0x1234; chan 3 slot 0xFF_8765_4321 -> data=0x87654321.
- Backpressure: chans 2 and 5 valid, wr_ready_i low 3 cycles, then high -> chan 2 request held stable 4 cycles, then chan 5; wb_ready_o=0 throughout.
- Misaligned base 0x1007 with chan 9 -> addr=0x1048; base changed to 0x2000 mid-burst -> remaining addrs still use 0x1000.
- Reset mid-burst after 3 of 6 handshakes -> wr_valid_o=0 next cycle, wr_cnt_o=0, wb_ready_o=1; no further requests.
- wr_cnt_o preloaded near wrap (force 0xFFFFFFFF) -> one handshake yields 0x00000000.
